fifo_wr_status: RTL

FIFO_WR_STATUS -- requirements
Module: fifo_wr_status

---
 rtl/fifo_wr_status.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_wr_status.sv
// Write-side status for an async FIFO: read-pointer sync, fill level, full/almost-full, overflow tracking.
// Latency: flags/level registered 1 clk after write pointer change; read pointer moves seen 3 clk later.
// Backpressure: o_wr_en gates i_wr_req combinationally with o_full; rejected writes are counted, not queued.
module fifo_wr_status #(
    parameter int PtrWidth = 2,
    parameter int AfThresh = 3
) (
    input  logic                clk,
    input  logic                rst_sync_n,
    input  logic                i_wr_req,
    input  logic [PtrWidth:0]   i_wr_bin_ptr_comb,
    input  logic [PtrWidth:0]   i_rd_gray_ptr,
    input  logic                i_ovf_clr,
    output logic                o_wr_en,
    output logic                o_full,
    output logic                o_almost_full,
    output logic [PtrWidth:0]   o_level,
    output logic                o_overflow,
    output logic [7:0]          o_drop_cnt
);

    localparam int Depth = 1 << PtrWidth;
    localparam logic [PtrWidth:0] DepthLv = Depth[PtrWidth:0];
    localparam logic [PtrWidth:0] AfLv    = AfThresh[PtrWidth:0];

    logic [PtrWidth:0] rd_gray_meta;
    logic [PtrWidth:0] rd_gray_sync;
    logic [PtrWidth:0] rd_bin_sync;
    logic [PtrWidth:0] level_nxt;
    logic              wr_reject;

    // Two-flop synchroniser for the remote gray read pointer; nothing between the stages.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rd_gray_meta <= '0;
            rd_gray_sync <= '0;
        end else begin
            rd_gray_meta <= i_rd_gray_ptr;
            rd_gray_sync <= rd_gray_meta;
        end
    end

    // Gray to binary: each binary bit is the XOR of the gray bits from itself up to the MSB.
    always_comb begin
        rd_bin_sync = '0;
        for (int i = 0; i <= PtrWidth; i++) begin
            rd_bin_sync[i] = ^(rd_gray_sync >> i);
        end
    end

    // Qualified write and fill level; modular subtraction absorbs pointer wrap.
    assign o_wr_en   = i_wr_req & ~o_full;
    assign wr_reject = i_wr_req & o_full;
    assign level_nxt = i_wr_bin_ptr_comb - rd_bin_sync;

    // Registered level and flags; a level beyond DEPTH (corrupt remote pointer) also reads as full.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            o_level       <= '0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
        end else begin
            o_level       <= level_nxt;
            o_full        <= (level_nxt >= DepthLv);
            o_almost_full <= (level_nxt >= AfLv);
        end
    end

    // Sticky overflow and saturating drop count; a rejected write wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= 8'd0;
        end else if (wr_reject) begin
            o_overflow <= 1'b1;
            if (i_ovf_clr) begin
                o_drop_cnt <= 8'd1;
            end else if (o_drop_cnt != 8'hFF) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= 8'd0;
        end
    end

endmodule
